// File: rtl/serdes_1_to_s_ddr_rx.sv
// Single-lane 4x-oversampling receiver: picks the sampling phase furthest from the
// observed data edges, deserialises MSB-first S-bit words, and supports bitslip.
module serdes_1_to_s_ddr_rx #(
    parameter int  S                     = 8,
    parameter int  D                     = 1,
    parameter real REF_FREQ              = 310.0,
    parameter      HIGH_PERFORMANCE_MODE = "TRUE",
    parameter      DATA_FORMAT           = "PER_CLOCK"
) (
    input  logic          rxclk,
    input  logic          reset,
    input  logic          datain_p,
    input  logic          datain_n,
    input  logic          enable_phase_detector,
    input  logic          enable_monitor,
    input  logic          bitslip,
    input  logic          idelay_rdy,
    input  logic [15:0]   bit_rate_value,
    input  logic          dcd_correct,
    output logic          rx_lckd,
    output logic [S-1:0]  rx_data,
    output logic          rx_data_valid,
    output logic [4:0]    bit_time_value,
    output logic [7:0]    debug,
    output logic [31:0]   eye_info,
    output logic [31:0]   m_delay_1hot,
    output logic [31:0]   clock_sweep
);
    localparam int CW = $clog2(S);

    if ((S != 4 && S != 6 && S != 8) || D != 1 || DATA_FORMAT != "PER_CLOCK" ||
        REF_FREQ < 0.0 || (HIGH_PERFORMANCE_MODE != "TRUE" && HIGH_PERFORMANCE_MODE != "FALSE")) begin : g_bad_cfg
        $error("serdes_1_to_s_ddr_rx: unsupported parameter set");
    end

    logic          s_q, s_d, sp_q, sp_d, bsp_q, bsp_d;
    logic [7:0]    win_q, win_d;
    logic [7:0]    cnt_q [4];
    logic [7:0]    cnt_d [4];
    logic [7:0]    cnt_upd [4];
    logic [1:0]    sel_q, sel_d;
    logic          lck_q, lck_d;
    logic [31:0]   eye_q, eye_d, sweep_q, sweep_d;
    logic [S-1:0]  sh_q, sh_d, data_q, data_d;
    logic [CW-1:0] bcnt_q, bcnt_d;
    logic [2:0]    pend_q, pend_d;
    logic          valid_q, valid_d;
    logic          edge_det, strobe, rise, consume;
    logic [1:0]    ctr, best_p;
    logic [7:0]    best_c;
    logic [9:0]    total;
    logic          unused_inputs;

    assign unused_inputs = ^{datain_n, bit_rate_value, dcd_correct, sh_q[S-1]};

    always_comb begin
        s_d      = datain_p;
        sp_d     = s_q;
        bsp_d    = bitslip;
        win_d    = win_q + 8'd1;
        sel_d    = sel_q;
        lck_d    = lck_q;
        eye_d    = eye_q;
        sweep_d  = sweep_q;
        sh_d     = sh_q;
        data_d   = data_q;
        bcnt_d   = bcnt_q;
        valid_d  = 1'b0;
        ctr      = win_q[1:0];
        edge_det = s_q ^ sp_q;
        strobe   = (ctr == sel_q);
        rise     = bitslip & ~bsp_q;
        consume  = strobe && (pend_q != 3'd0);
        total    = '0;
        best_c   = '0;
        best_p   = '0;

        // the final cycle's edge belongs to the window it closes
        for (int p = 0; p < 4; p++) begin
            cnt_upd[p] = cnt_q[p];
            if (edge_det && ctr == 2'(p) && cnt_q[p] != 8'hff)
                cnt_upd[p] = cnt_q[p] + 8'd1;
            cnt_d[p] = cnt_upd[p];
            total    = total + 10'(cnt_upd[p]);
        end
        best_c = cnt_upd[0];
        for (int p = 1; p < 4; p++) begin
            if (cnt_upd[p] > best_c) begin
                best_c = cnt_upd[p];
                best_p = 2'(p);
            end
        end

        if (strobe) begin
            sh_d = {sh_q[S-2:0], s_q};
            if (!consume) begin
                if (bcnt_q == CW'(S-1)) begin
                    data_d  = {sh_q[S-2:0], s_q};
                    valid_d = 1'b1;
                    bcnt_d  = '0;
                end else begin
                    bcnt_d = bcnt_q + CW'(1);
                end
            end
        end

        pend_d = pend_q;
        if (consume)
            pend_d = pend_d - 3'd1;
        if (rise && pend_d != 3'd7)
            pend_d = pend_d + 3'd1;

        if (win_q == 8'hff) begin
            eye_d   = enable_monitor ? {cnt_upd[3], cnt_upd[2], cnt_upd[1], cnt_upd[0]} : 32'd0;
            if (enable_phase_detector && total != 10'd0)
                sel_d = best_p + 2'd2;
            if (total >= 10'd8)
                lck_d = 1'b1;
            else if (total == 10'd0)
                lck_d = 1'b0;
            sweep_d = sweep_q + 32'd1;
            for (int p = 0; p < 4; p++)
                cnt_d[p] = '0;
        end
        if (!enable_monitor)
            eye_d = 32'd0;
    end

    always_ff @(posedge rxclk) begin
        if (reset || !idelay_rdy) begin
            s_q     <= 1'b0;
            sp_q    <= 1'b0;
            bsp_q   <= 1'b0;
            win_q   <= '0;
            sel_q   <= 2'd2;
            lck_q   <= 1'b0;
            eye_q   <= '0;
            sweep_q <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            bcnt_q  <= '0;
            pend_q  <= '0;
            valid_q <= 1'b0;
            for (int p = 0; p < 4; p++)
                cnt_q[p] <= '0;
        end else begin
            s_q     <= s_d;
            sp_q    <= sp_d;
            bsp_q   <= bsp_d;
            win_q   <= win_d;
            sel_q   <= sel_d;
            lck_q   <= lck_d;
            eye_q   <= eye_d;
            sweep_q <= sweep_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            bcnt_q  <= bcnt_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
            for (int p = 0; p < 4; p++)
                cnt_q[p] <= cnt_d[p];
        end
    end

    assign rx_lckd        = lck_q;
    assign rx_data        = data_q;
    assign rx_data_valid  = valid_q;
    assign bit_time_value = 5'd4;
    assign debug          = {sel_q, 6'b0};
    assign eye_info       = eye_q;
    assign m_delay_1hot   = 32'd1 << sel_q;
    assign clock_sweep    = sweep_q;
endmodule

// File: tb/tb_serdes_1_to_s_ddr_rx.sv
// Bench for serdes_1_to_s_ddr_rx: behavioural model of windows, phase choice and word
// framing, compared against the DUT every cycle, plus hand-computed checkpoints.
module tb_serdes_1_to_s_ddr_rx;
    localparam int S = 8;

    logic          rxclk = 1'b0;
    logic          reset, datain_p, datain_n, enable_phase_detector, enable_monitor;
    logic          bitslip, idelay_rdy, dcd_correct;
    logic [15:0]   bit_rate_value;
    logic          rx_lckd, rx_data_valid;
    logic [S-1:0]  rx_data;
    logic [4:0]    bit_time_value;
    logic [7:0]    debug;
    logic [31:0]   eye_info, m_delay_1hot, clock_sweep;

    always #5 rxclk = ~rxclk;

    serdes_1_to_s_ddr_rx #(.S(S)) dut (
        .rxclk(rxclk), .reset(reset), .datain_p(datain_p), .datain_n(datain_n),
        .enable_phase_detector(enable_phase_detector), .enable_monitor(enable_monitor),
        .bitslip(bitslip), .idelay_rdy(idelay_rdy), .bit_rate_value(bit_rate_value),
        .dcd_correct(dcd_correct), .rx_lckd(rx_lckd), .rx_data(rx_data),
        .rx_data_valid(rx_data_valid), .bit_time_value(bit_time_value), .debug(debug),
        .eye_info(eye_info), .m_delay_1hot(m_delay_1hot), .clock_sweep(clock_sweep)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: cycle index in the window, edge histogram, strobed-bit history
    int          m_cyc, m_sel, m_n, m_pend;
    int          m_cnt [4];
    bit          m_s, m_sp, m_bp, m_lck, m_valid;
    bit          m_hist[$];
    logic [31:0] m_eye, m_sweep;
    logic [S-1:0] m_data;

    always @(posedge rxclk) begin
        if (reset || !idelay_rdy) begin
            m_cyc = 0; m_sel = 2; m_n = 0; m_pend = 0;
            m_s = 0; m_sp = 0; m_bp = 0; m_lck = 0; m_valid = 0;
            m_eye = 0; m_sweep = 0; m_data = 0;
            for (int p = 0; p < 4; p++) m_cnt[p] = 0;
            m_hist.delete();
            for (int i = 0; i < S; i++) m_hist.push_back(1'b0);
        end else begin
            automatic int ph = m_cyc % 4;
            automatic bit rise = bitslip && !m_bp;
            if (m_s != m_sp && m_cnt[ph] < 255) m_cnt[ph]++;
            m_valid = 0;
            if (ph == m_sel) begin
                m_hist.push_back(m_s);
                if (m_hist.size() > S) void'(m_hist.pop_front());
                if (m_pend > 0) m_pend--;
                else begin
                    m_n++;
                    if (m_n == S) begin
                        for (int i = 0; i < S; i++) m_data[S-1-i] = m_hist[i];
                        m_valid = 1;
                        m_n = 0;
                    end
                end
            end
            if (rise && m_pend < 7) m_pend++;
            if (m_cyc == 255) begin
                automatic int tot = m_cnt[0] + m_cnt[1] + m_cnt[2] + m_cnt[3];
                automatic int e = 0;
                m_eye = enable_monitor ? {8'(m_cnt[3]), 8'(m_cnt[2]), 8'(m_cnt[1]), 8'(m_cnt[0])} : 32'd0;
                for (int p = 1; p < 4; p++) if (m_cnt[p] > m_cnt[e]) e = p;
                if (enable_phase_detector && tot > 0) m_sel = (e + 2) % 4;
                if (tot >= 8) m_lck = 1;
                else if (tot == 0) m_lck = 0;
                m_sweep = m_sweep + 1;
                for (int p = 0; p < 4; p++) m_cnt[p] = 0;
            end
            if (!enable_monitor) m_eye = 0;
            m_sp = m_s;
            m_s = datain_p;
            m_bp = bitslip;
            m_cyc = (m_cyc + 1) % 256;
        end
    end

    bit cmp_en = 0;
    always @(negedge rxclk) begin
        if (cmp_en) begin
            check("valid", {31'd0, rx_data_valid}, {31'd0, m_valid});
            check("rx_data", 32'(rx_data), 32'(m_data));
            check("lckd", {31'd0, rx_lckd}, {31'd0, m_lck});
            check("debug", 32'(debug), 32'(m_sel) << 6);
            check("onehot", m_delay_1hot, 32'd1 << m_sel);
            check("eye", eye_info, m_eye);
            check("sweep", clock_sweep, m_sweep);
            check("bit_time", 32'(bit_time_value), 32'd4);
        end
    end

    // driver: one new bit per bit time, changed when the window counter is at chg_ph,
    // so the edge is seen at phase chg_ph+1
    int         mode = 0;
    int         chg_ph = 3;
    int         bit_idx = 0;
    logic [7:0] pat = 8'h01;

    function automatic logic next_bit();
        case (mode)
            0:       return logic'(bit_idx % 2);
            1:       return pat[7 - (bit_idx % 8)];
            2:       return 1'b1;
            default: return logic'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge rxclk);
            if (m_cyc % 4 == chg_ph) begin
                bit_idx++;
                datain_p = next_bit();
            end
        end
    endtask

    task automatic slip_pulse();
        bitslip = 1'b1;
        cycles(2);
        bitslip = 1'b0;
        cycles(38);
    endtask

    initial begin
        int pulses;
        reset = 1; idelay_rdy = 1; datain_p = 0; datain_n = 1; bitslip = 0;
        enable_phase_detector = 1; enable_monitor = 1; dcd_correct = 0; bit_rate_value = 16'h1234;
        @(posedge rxclk);
        @(negedge rxclk);
        cmp_en = 1;
        cycles(3);
        check("rst_data", 32'(rx_data), 32'h0);
        check("rst_debug", 32'(debug), 32'h80);
        check("rst_onehot", m_delay_1hot, 32'h4);
        check("rst_lckd", {31'd0, rx_lckd}, 32'h0);
        check("rst_sweep", clock_sweep, 32'h0);

        reset = 0; idelay_rdy = 0;
        cycles(300);
        check("idle_sweep", clock_sweep, 32'h0);
        check("idle_debug", 32'(debug), 32'h80);
        check("idle_eye", eye_info, 32'h0);

        idelay_rdy = 1; mode = 0; chg_ph = 3;
        cycles(256 * 3);
        check("alt_eye0", eye_info, 32'h40);
        check("alt_debug", 32'(debug), 32'h80);
        check("alt_onehot", m_delay_1hot, 32'h4);
        check("alt_lckd", {31'd0, rx_lckd}, 32'h1);

        mode = 1;
        cycles(100);
        pulses = 0;
        while (rx_data !== 8'h01 && pulses < 8) begin
            slip_pulse();
            pulses++;
            cycles(100);
        end
        check("align_pulses_le7", {31'd0, pulses <= 7}, 32'h1);
        check("aligned", 32'(rx_data), 32'h01);
        repeat (8) slip_pulse();
        cycles(100);
        check("eight_slips", 32'(rx_data), 32'h01);
        bitslip = 1;
        cycles(100);
        bitslip = 0;
        cycles(100);
        check("held_one_slip", {31'd0, rx_data == 8'h01}, 32'h0);
        repeat (7) slip_pulse();
        cycles(100);
        check("held_plus_seven", 32'(rx_data), 32'h01);

        mode = 2;
        cycles(256 * 3);
        check("const_lckd", {31'd0, rx_lckd}, 32'h0);
        check("const_debug", 32'(debug), 32'h80);

        mode = 0; chg_ph = 2; enable_phase_detector = 0;
        cycles(256 * 3);
        check("pd_off_debug", 32'(debug), 32'h80);
        check("pd_off_eye3", eye_info, 32'h4000_0000);
        enable_phase_detector = 1;
        cycles(256 * 2);
        check("pd_on_debug", 32'(debug), 32'h40);
        check("pd_on_onehot", m_delay_1hot, 32'h2);

        mode = 3;
        for (int seg = 0; seg < 40; seg++) begin
            chg_ph = $urandom_range(0, 3);
            enable_monitor = ($urandom_range(0, 7) != 0);
            enable_phase_detector = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 9))
                0: begin reset = 1; cycles(2); reset = 0; end
                1: begin idelay_rdy = 0; cycles(5); idelay_rdy = 1; end
                2, 3: begin bitslip = 1; cycles(2); bitslip = 0; cycles(2); bitslip = 1; cycles(1); bitslip = 0; end
                default: ;
            endcase
            cycles($urandom_range(40, 200));
        end

        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
